// File: rtl/imem_boot_loader_pkg.sv
// Shared encodings and frame constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Big-endian byte-to-word packer: first byte of each group of four is the MSB.
module byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam int IW = $clog2(BYTES_PER_WORD);
  localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic [23:0]   sh_q, sh_d;

  // The completing byte is forwarded directly so the word is ready on the 4th transfer.
  assign word_valid_o = en_i && (idx_q == LAST);
  assign word_o       = {sh_q, byte_i};

  always_comb begin
    idx_d = idx_q;
    sh_d  = sh_q;
    if (en_i) begin
      sh_d  = {sh_q[15:0], byte_i};
      idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q <= '0;
      sh_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame,
// writes it into instruction memory and releases the core on success.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state_q;
  logic [7:0]        len_hi_q;
  logic [15:0]       n_q;
  logic [15:0]       wcnt_q;
  logic [7:0]        csum_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;

  logic        xfer;
  logic        pk_en;
  logic        pk_valid;
  logic [31:0] pk_word;
  logic [15:0] len_w;

  assign byte_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign xfer  = byte_valid && byte_ready;
  assign pk_en = xfer && (state_q == ST_DATA);
  assign len_w = {len_hi_q, byte_data};

  byte_packer u_packer (
    .CLK          (CLK),
    .RST          (RST),
    .en_i         (pk_en),
    .byte_i       (byte_data),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      len_hi_q  <= '0;
      n_q       <= '0;
      wcnt_q    <= '0;
      csum_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: state_q <= ST_LEN_HI;
        ST_LEN_HI: begin
          if (xfer) begin
            len_hi_q <= byte_data;
            state_q  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            n_q <= len_w;
            if (len_w == 16'd0) begin
              state_q <= ST_CSUM;
            end else if ({1'b0, len_w} > DEPTH) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            csum_q <= csum_q ^ byte_data;
            if (pk_valid) begin
              we_q    <= 1'b1;
              addr_q  <= wcnt_q[ADDR_W-1:0];
              wdata_q <= pk_word;
              wcnt_q  <= wcnt_q + 16'd1;
              if (wcnt_q == n_q - 16'd1) state_q <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            if (byte_data == csum_q) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERR: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench: frame-position model checked every cycle plus literal pins.
module tb_imem_boot_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  imem_boot_loader dut (
    .CLK        (CLK),
    .RST        (RST),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: everything derives from how many bytes have been consumed.
  bit          m_started, m_done, m_err, m_we;
  int          m_cnt, m_N, m_waddr;
  logic [7:0]  m_hi, m_xor;
  logic [31:0] m_word, m_wdata;

  function automatic bit m_ready();
    return m_started && !m_done && !m_err;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_started = 0; m_done = 0; m_err = 0; m_we = 0;
      m_cnt = 0; m_N = 0; m_waddr = 0;
      m_hi = 0; m_xor = 0; m_word = 0; m_wdata = 0;
    end else begin
      m_we = 0;
      if (byte_valid && m_ready()) begin
        if (m_cnt == 0) begin
          m_hi = byte_data;
        end else if (m_cnt == 1) begin
          m_N = int'({m_hi, byte_data});
          if (m_N > 256) m_err = 1;
        end else if (m_cnt < 2 + 4 * m_N) begin
          m_xor  = m_xor ^ byte_data;
          m_word = {m_word[23:0], byte_data};
          if ((m_cnt - 2) % 4 == 3) begin
            m_we    = 1;
            m_waddr = (m_cnt - 2) / 4;
            m_wdata = m_word;
          end
        end else begin
          m_done = (byte_data == m_xor);
          m_err  = (byte_data != m_xor);
        end
        m_cnt++;
      end
      m_started = 1;
    end
  end

  logic [31:0] mem [256];
  int          nwr = 0;
  logic [7:0]  last_addr = 8'h00;

  always @(negedge CLK) begin
    chk1("byte_ready", byte_ready, m_ready());
    chk1("imem_we", imem_we, m_we);
    if (m_we) begin
      chk32("imem_addr", 32'(imem_addr), 32'(m_waddr));
      chk32("imem_wdata", imem_wdata, m_wdata);
    end
    chk1("load_done", load_done, m_done);
    chk1("load_err", load_err, m_err);
    chk1("cpu_rst", cpu_rst, !m_done);
    chk1("done_err_excl", load_done & load_err, 1'b0);
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      nwr++;
      last_addr = imem_addr;
    end
  end

  logic [7:0] frm[$];

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge CLK);
      byte_valid = 1'b0;
    end
    @(negedge CLK);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 20) begin
      @(negedge CLK);
      t++;
    end
    chk1("ready_timeout", byte_ready, 1'b1);
  endtask

  task automatic send_frame(input int gap);
    foreach (frm[i]) send_byte(frm[i], gap);
    @(negedge CLK);
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    byte_valid = 1'b0;
    #1;
    chk1("rst_ready", byte_ready, 1'b0);
    chk1("rst_we", imem_we, 1'b0);
    chk32("rst_addr", 32'(imem_addr), 32'h0);
    chk32("rst_wdata", imem_wdata, 32'h0);
    chk1("rst_cpu_rst", cpu_rst, 1'b1);
    chk1("rst_done", load_done, 1'b0);
    chk1("rst_err", load_err, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    nwr = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  task automatic settle();
    repeat (3) @(negedge CLK);
  endtask

  logic [7:0] cs;

  initial begin
    do_reset();

    // 1: two words, full rate
    frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h20, 8'h09, 8'h00, 8'h07, 8'h03};
    send_frame(0);
    settle();
    chk32("t1_mem0", mem[0], 32'h20080005);
    chk32("t1_mem1", mem[1], 32'h20090007);
    chk32("t1_nwr", 32'(nwr), 32'd2);
    chk1("t1_done", load_done, 1'b1);
    chk1("t1_cpu_rst", cpu_rst, 1'b0);
    chk1("t1_ready", byte_ready, 1'b0);

    // 2: same frame, valid toggling
    do_reset();
    send_frame(1);
    settle();
    chk32("t2_mem0", mem[0], 32'h20080005);
    chk32("t2_mem1", mem[1], 32'h20090007);
    chk32("t2_nwr", 32'(nwr), 32'd2);
    chk1("t2_done", load_done, 1'b1);

    // 3: bad checksum (correct would be 0x00)
    do_reset();
    frm = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    send_frame(0);
    settle();
    chk32("t3_mem0", mem[0], 32'hAABBCCDD);
    chk32("t3_nwr", 32'(nwr), 32'd1);
    chk1("t3_err", load_err, 1'b1);
    chk1("t3_cpu_rst", cpu_rst, 1'b1);
    chk1("t3_ready", byte_ready, 1'b0);

    // 4a: empty image
    do_reset();
    frm = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    settle();
    chk32("t4a_nwr", 32'(nwr), 32'd0);
    chk1("t4a_done", load_done, 1'b1);

    // 4b: one word too many
    do_reset();
    frm = '{8'h01, 8'h01};
    send_frame(0);
    settle();
    chk32("t4b_nwr", 32'(nwr), 32'd0);
    chk1("t4b_err", load_err, 1'b1);
    chk1("t4b_cpu_rst", cpu_rst, 1'b1);

    // 5: fill memory exactly
    do_reset();
    frm = '{8'h01, 8'h00};
    cs = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      frm.push_back(pat(i));
      cs = cs ^ pat(i);
    end
    frm.push_back(cs);
    send_frame(0);
    settle();
    chk32("t5_nwr", 32'(nwr), 32'd256);
    chk32("t5_last_addr", 32'(last_addr), 32'd255);
    chk32("t5_mem255", mem[255], {pat(1020), pat(1021), pat(1022), pat(1023)});
    chk32("t5_mem0", mem[0], {pat(0), pat(1), pat(2), pat(3)});
    chk1("t5_done", load_done, 1'b1);

    // 6: reset mid word 1, then a clean frame
    do_reset();
    frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
    foreach (frm[i]) send_byte(frm[i], 0);
    do_reset();
    frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h20, 8'h09, 8'h00, 8'h07, 8'h03};
    send_frame(0);
    settle();
    chk32("t6_mem0", mem[0], 32'h20080005);
    chk32("t6_mem1", mem[1], 32'h20090007);
    chk32("t6_nwr", 32'(nwr), 32'd2);
    chk1("t6_done", load_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
